// File: rtl/serial_subtractor_pkg.sv
// ============================================================================
// Module   : serial_subtractor_pkg
// Purpose  : Shared FSM state type, default operand width and sizing helper.
// Revision : 1.0
// ============================================================================
`default_nettype none

package serial_subtractor_pkg;

  localparam int DEFAULT_WIDTH = 4;

  typedef enum logic [0:0] {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } state_t;

  // Bit counter width, never narrower than one bit.
  function automatic int cnt_bits(input int w);
    return (w <= 2) ? 1 : $clog2(w);
  endfunction

endpackage

`default_nettype wire

// File: rtl/serial_subtractor_if.sv
// ============================================================================
// Module   : serial_subtractor_if
// Purpose  : Request/result bundle between a requester and serial_subtractor.
// Revision : 1.0
// ============================================================================
`default_nettype none

interface serial_subtractor_if
  import serial_subtractor_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
);

  logic             start;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             busy;
  logic             done;
  logic [WIDTH:0]   diff;

  modport master (
    output start,
    output a,
    output b,
    input  busy,
    input  done,
    input  diff
  );

  modport slave (
    input  start,
    input  a,
    input  b,
    output busy,
    output done,
    output diff
  );

endinterface

`default_nettype wire

// File: rtl/serial_subtractor_full_subtractor.sv
// ============================================================================
// Module   : full_subtractor
// Purpose  : One-bit subtract cell: d = x - y - bin, bout = borrow out.
// Revision : 1.0
// ============================================================================
`default_nettype none

module full_subtractor (
  input  wire logic x,
  input  wire logic y,
  input  wire logic bin,
  output logic      d,
  output logic      bout
);

  assign d    = x ^ y ^ bin;
  assign bout = (~x & y) | (~(x ^ y) & bin);

endmodule

`default_nettype wire

// File: rtl/serial_subtractor.sv
// ============================================================================
// Module   : serial_subtractor
// Purpose  : Bit-serial (LSB-first) unsigned subtractor, one bit per clock.
// Revision : 1.0
// ============================================================================
`default_nettype none

module serial_subtractor
  import serial_subtractor_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  wire logic     clk,
  input  wire logic     reset,
  serial_subtractor_if.slave bus
);

  localparam int             CW       = cnt_bits(WIDTH);
  localparam logic [CW-1:0]  CNT_LAST = CW'(WIDTH - 1);

  state_t           state_q, state_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic [WIDTH-1:0] res_q, res_d;
  logic             borrow_q, borrow_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic [WIDTH:0]   diff_q, diff_d;

  logic             fs_d;
  logic             fs_bout;

  full_subtractor u_fs (
    .x    (a_q[0]),
    .y    (b_q[0]),
    .bin  (borrow_q),
    .d    (fs_d),
    .bout (fs_bout)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= IDLE;
      a_q      <= '0;
      b_q      <= '0;
      res_q    <= '0;
      borrow_q <= 1'b0;
      cnt_q    <= '0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      diff_q   <= '0;
    end else begin
      state_q  <= state_d;
      a_q      <= a_d;
      b_q      <= b_d;
      res_q    <= res_d;
      borrow_q <= borrow_d;
      cnt_q    <= cnt_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
      diff_q   <= diff_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    a_d      = a_q;
    b_d      = b_q;
    res_d    = res_q;
    borrow_d = borrow_q;
    cnt_d    = cnt_q;
    busy_d   = busy_q;
    done_d   = 1'b0;
    diff_d   = diff_q;

    case (state_q)
      IDLE: begin
        if (bus.start) begin
          a_d      = bus.a;
          b_d      = bus.b;
          res_d    = '0;
          borrow_d = 1'b0;
          cnt_d    = '0;
          busy_d   = 1'b1;
          state_d  = SHIFT;
        end
      end

      SHIFT: begin
        // Result fills from the top so bit 0 lands at the LSB after WIDTH shifts.
        a_d      = a_q >> 1;
        b_d      = b_q >> 1;
        res_d    = {fs_d, res_q[WIDTH-1:1]};
        borrow_d = fs_bout;
        if (cnt_q == CNT_LAST) begin
          cnt_d   = '0;
          busy_d  = 1'b0;
          done_d  = 1'b1;
          diff_d  = {fs_bout, fs_d, res_q[WIDTH-1:1]};
          state_d = IDLE;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end

      default: state_d = IDLE;
    endcase
  end

  assign bus.busy = busy_q;
  assign bus.done = done_q;
  assign bus.diff = diff_q;

endmodule

`default_nettype wire

// File: tb/tb_serial_subtractor.sv
// ============================================================================
// Module   : tb_serial_subtractor
// Purpose  : Self-checking bench for serial_subtractor at WIDTH=4.
// Revision : 1.0
// ============================================================================
`default_nettype none

module tb_serial_subtractor;

  localparam int W = 4;

  logic clk = 1'b0;
  logic reset;

  int n_checks = 0;
  int n_fail   = 0;

  serial_subtractor_if #(.WIDTH(W)) bus ();

  serial_subtractor #(.WIDTH(W)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  // Reference: borrow flag is an unsigned compare, low bits are modular difference.
  function automatic logic [W:0] ref_sub(input int x, input int y);
    int r;
    r = x - y;
    if (r < 0) r = r + (1 << W);
    return {(x < y) ? 1'b1 : 1'b0, W'(r)};
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Launches one operation and waits (bounded) for done; optional noise on
  // start/a/b while busy. lat = -1 when done never arrives.
  task automatic run_op(input logic [W-1:0] ta, input logic [W-1:0] tb,
                        input bit noise, output int lat, output int nbusy,
                        output logic busy_at_done, output logic [W:0] res);
    bus.start = 1'b1;
    bus.a     = ta;
    bus.b     = tb;
    step();
    bus.start    = 1'b0;
    lat          = -1;
    res          = '0;
    busy_at_done = 1'b1;
    nbusy        = bus.busy ? 1 : 0;
    for (int k = 1; k <= 3 * W; k++) begin
      if (noise) begin
        bus.start = 1'($urandom_range(0, 1));
        bus.a     = W'($urandom);
        bus.b     = W'($urandom);
      end
      step();
      if (bus.done) begin
        bus.start    = 1'b0;
        lat          = k;
        res          = bus.diff;
        busy_at_done = bus.busy;
        break;
      end
      if (bus.busy) nbusy++;
    end
    bus.start = 1'b0;
  endtask

  task automatic test_reset();
    reset     = 1'b1;
    bus.start = 1'b1;
    bus.a     = 4'd9;
    bus.b     = 4'd3;
    for (int i = 0; i < 3; i++) begin
      step();
      n_checks++;
      if ({bus.busy, bus.done, bus.diff} !== 7'b0) begin
        n_fail++;
        $display("FAIL reset_state: busy=%b done=%b diff=%b, required 0 0 00000",
                 bus.busy, bus.done, bus.diff);
      end
    end
    bus.start = 1'b0;
    reset     = 1'b0;
    step();
  endtask

  task automatic test_directed();
    logic [W-1:0] va [5] = '{4'd9, 4'd3, 4'd0, 4'd15, 4'd0};
    logic [W-1:0] vb [5] = '{4'd3, 4'd9, 4'd15, 4'd0, 4'd0};
    logic [W:0]   exp [5] = '{5'b00110, 5'b11010, 5'b10001, 5'b01111, 5'b00000};
    int lat, nb;
    logic bd;
    logic [W:0] res;
    for (int i = 0; i < 5; i++) begin
      run_op(va[i], vb[i], 1'b0, lat, nb, bd, res);
      n_checks++;
      if (res !== exp[i]) begin
        n_fail++;
        $display("FAIL directed_diff[%0d]: got %b, required %b", i, res, exp[i]);
      end
      n_checks++;
      if (lat !== W) begin
        n_fail++;
        $display("FAIL directed_latency[%0d]: got %0d, required %0d", i, lat, W);
      end
      n_checks++;
      if (nb !== W || bd !== 1'b0) begin
        n_fail++;
        $display("FAIL directed_busy[%0d]: busy cycles %0d busy_at_done %b, required %0d 0",
                 i, nb, bd, W);
      end
      step();
    end
  endtask

  task automatic test_ignore_busy();
    int lat;
    bus.start = 1'b1;
    bus.a     = 4'd9;
    bus.b     = 4'd3;
    step();
    bus.start = 1'b0;
    lat       = -1;
    for (int k = 1; k <= 3 * W; k++) begin
      bus.start = (k == 2);
      if (k == 2) begin
        bus.a = 4'd1;
        bus.b = 4'd2;
      end
      step();
      if (bus.done) begin
        lat = k;
        break;
      end
    end
    bus.start = 1'b0;
    n_checks++;
    if (lat !== W || bus.diff !== 5'b00110) begin
      n_fail++;
      $display("FAIL ignore_busy: latency %0d diff %b, required %0d 00110", lat, bus.diff, W);
    end
    step();
    n_checks++;
    if (bus.busy !== 1'b0) begin
      n_fail++;
      $display("FAIL ignore_busy_idle: busy=%b, required 0", bus.busy);
    end
  endtask

  task automatic test_back_to_back();
    int lat1, lat2, held_bad;
    bus.start = 1'b1;
    bus.a     = 4'd7;
    bus.b     = 4'd2;
    step();
    bus.a = 4'd2;
    bus.b = 4'd7;
    lat1  = -1;
    for (int k = 1; k <= 3 * W; k++) begin
      step();
      if (bus.done) begin
        lat1 = k;
        break;
      end
    end
    n_checks++;
    if (lat1 !== W || bus.diff !== 5'b00101) begin
      n_fail++;
      $display("FAIL b2b_first: latency %0d diff %b, required %0d 00101", lat1, bus.diff, W);
    end
    // start is still high during this done cycle, so it must be taken now
    step();
    bus.start = 1'b0;
    bus.a     = 4'd0;
    bus.b     = 4'd0;
    n_checks++;
    if (bus.busy !== 1'b1) begin
      n_fail++;
      $display("FAIL b2b_accept: busy=%b, required 1", bus.busy);
    end
    lat2     = -1;
    held_bad = 0;
    for (int k = 1; k <= 3 * W; k++) begin
      step();
      if (bus.done) begin
        lat2 = k;
        break;
      end
      if (bus.diff !== 5'b00101) held_bad++;
    end
    n_checks++;
    if (held_bad !== 0) begin
      n_fail++;
      $display("FAIL b2b_hold: diff changed in %0d cycles, required 0", held_bad);
    end
    n_checks++;
    if (lat2 !== W || bus.diff !== 5'b11011) begin
      n_fail++;
      $display("FAIL b2b_second: latency %0d diff %b, required %0d 11011", lat2, bus.diff, W);
    end
    step();
  endtask

  task automatic test_reset_mid_op();
    int lat, nb, spurious;
    logic bd;
    logic [W:0] res;
    bus.start = 1'b1;
    bus.a     = 4'd9;
    bus.b     = 4'd3;
    step();
    bus.start = 1'b0;
    step();
    step();
    reset = 1'b1;
    step();
    n_checks++;
    if ({bus.busy, bus.done, bus.diff} !== 7'b0) begin
      n_fail++;
      $display("FAIL reset_mid_op: busy=%b done=%b diff=%b, required 0 0 00000",
               bus.busy, bus.done, bus.diff);
    end
    reset    = 1'b0;
    spurious = 0;
    for (int k = 0; k < 2 * W; k++) begin
      step();
      if (bus.done || bus.busy) spurious++;
    end
    n_checks++;
    if (spurious !== 0) begin
      n_fail++;
      $display("FAIL reset_abort: %0d cycles with busy/done, required 0", spurious);
    end
    run_op(4'd5, 4'd5, 1'b0, lat, nb, bd, res);
    n_checks++;
    if (lat !== W || res !== 5'b00000) begin
      n_fail++;
      $display("FAIL after_reset_op: latency %0d diff %b, required %0d 00000", lat, res, W);
    end
    step();
  endtask

  task automatic test_random();
    int lat, nb, ta, tb;
    logic bd;
    logic [W:0] res, exp;
    for (int i = 0; i < 1000; i++) begin
      ta  = int'($urandom_range(0, (1 << W) - 1));
      tb  = int'($urandom_range(0, (1 << W) - 1));
      exp = ref_sub(ta, tb);
      run_op(W'(ta), W'(tb), 1'b1, lat, nb, bd, res);
      n_checks++;
      if (res !== exp || lat !== W) begin
        n_fail++;
        $display("FAIL random[%0d] a=%0d b=%0d: diff %b latency %0d, required %b %0d",
                 i, ta, tb, res, lat, exp, W);
      end
    end
  endtask

  initial begin
    reset     = 1'b1;
    bus.start = 1'b0;
    bus.a     = '0;
    bus.b     = '0;
    test_reset();
    test_directed();
    test_ignore_busy();
    test_back_to_back();
    test_reset_mid_op();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
